// File: rtl/mul_div_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mul_div_unit                                                   |
// | Brief   : Iterative multiply/divide unit with architectural HI/LO.       |
// |           Signed MULT/DIV built only when MDU_SIGNED_EN is defined.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                 C_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_is_div;
  logic                 r_b_zero;
  logic [WIDTH-1:0]     r_opnd;
  logic [WIDTH-1:0]     r_a_raw;
  logic [2*WIDTH-1:0]   r_acc;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  // Operand magnitudes and final sign correction exist only in the signed build.
`ifdef MDU_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_neg_q;
  logic r_neg_r;

  assign w_neg_a = op[1] & a[WIDTH-1];
  assign w_neg_b = op[1] & b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -a : a;
  assign w_mag_b = w_neg_b ? -b : b;
  assign w_prod  = r_neg_q ? -r_acc : r_acc;
  assign w_quo   = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem   = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
`else
  logic w_unused_op1;

  assign w_unused_op1 = op[1];
  assign w_mag_a      = a;
  assign w_mag_b      = b;
  assign w_prod       = r_acc;
  assign w_quo        = r_acc[WIDTH-1:0];
  assign w_rem        = r_acc[2*WIDTH-1:WIDTH];
`endif

  // One iteration of shift-add multiply or restoring shift-subtract divide.
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_trial;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_addend    = r_acc[0] ? r_opnd : {WIDTH{1'b0}};
  assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
  assign w_div_rem   = WIDTH'(w_div_trial - {1'b0, r_opnd});

  always_comb begin
    w_acc_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (w_div_ge) begin
        w_acc_next = {w_div_rem, r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_next = {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Divide by zero reports the raw dividend in HI regardless of signedness.
  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_b_zero) begin
        w_res_hi = r_a_raw;
        w_res_lo = {WIDTH{1'b1}};
      end else begin
        w_res_hi = w_rem;
        w_res_lo = w_quo;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
      r_opnd   <= '0;
      r_a_raw  <= '0;
      r_acc    <= '0;
`ifdef MDU_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (hi_we) r_hi <= wdata;
          if (lo_we) r_lo <= wdata;
          if (start) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_is_div <= op[0];
            r_b_zero <= (b == {WIDTH{1'b0}});
            r_a_raw  <= a;
            r_opnd   <= op[0] ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (op[0] ? w_mag_a : w_mag_b)};
`ifdef MDU_SIGNED_EN
            r_neg_q  <= w_neg_a ^ w_neg_b;
            r_neg_r  <= w_neg_a;
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + C_ONE;
          if (r_cnt == C_LAST) r_state <= S_FIN;
        end
        S_FIN: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire
